// File: rtl/dcsk_pkg.sv
// Shared definitions for the DCSK demodulator slice.
// Holds the default geometry (MAX_SF, MSG_W), the frame state type and the
// spreading-factor clamp helper used when a frame start latches i_sf.
package dcsk_pkg;

  localparam int unsigned DCSK_MAX_SF = 32;
  localparam int unsigned DCSK_MSG_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } dcsk_demod_state_t;

  // Zero or anything above the buffer depth falls back to the full depth.
  function automatic int unsigned clamp_sf(input int unsigned sf, input int unsigned max_sf);
    if (sf == 0 || sf > max_sf) begin
      return max_sf;
    end
    return sf;
  endfunction

endpackage

// File: rtl/dcsk_corr.sv
// DCSK correlator: reference chip buffer, chip index, match counter and the
// per-bit majority decision.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         restart the half-bit counters this cycle (frame start/abort)
//   sf            chips per half-bit in effect this cycle
//   half          0 = reference half (store), 1 = data half (compare)
//   valid, chip   accepted chip and its value
//   done          combinational: this accepted chip completes the current half
//   dec_bit, tie  combinational decision, meaningful when done in the data half
module dcsk_corr
  import dcsk_pkg::*;
#(
  parameter int unsigned MAX_SF = DCSK_MAX_SF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [$clog2(MAX_SF):0]     sf,
  input  logic                        half,
  input  logic                        valid,
  input  logic                        chip,
  output logic                        done,
  output logic                        dec_bit,
  output logic                        tie
);

  localparam int unsigned SF_W  = $clog2(MAX_SF) + 1;
  localparam int unsigned IDX_W = $clog2(MAX_SF);

  logic [MAX_SF-1:0] ref_q;
  logic [SF_W-1:0]   idx_q, idx_cur;
  logic [SF_W-1:0]   match_q, match_cur, match_fin;
  logic              is_match;
  logic              last;

  // A clear takes effect in the same cycle, so a chip arriving with the
  // frame start is treated as index 0 of a fresh reference half.
  always_comb begin
    idx_cur   = clear ? '0 : idx_q;
    match_cur = clear ? '0 : match_q;
    is_match  = (chip == ref_q[idx_cur[IDX_W-1:0]]);
    match_fin = match_cur + SF_W'(is_match);
    last      = (idx_cur == sf - SF_W'(1));
    done      = valid && last;
    dec_bit   = ({match_fin, 1'b0} > {1'b0, sf});
    tie       = ({match_fin, 1'b0} == {1'b0, sf});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q   <= '0;
      idx_q   <= '0;
      match_q <= '0;
    end else begin
      if (clear) begin
        idx_q   <= '0;
        match_q <= '0;
      end
      if (valid) begin
        if (!half) begin
          ref_q[idx_cur[IDX_W-1:0]] <= chip;
        end
        idx_q   <= last ? '0 : idx_cur + SF_W'(1);
        match_q <= (half && !last) ? match_fin : '0;
      end
    end
  end

endmodule

// File: rtl/dcsk_demod.sv
// Binary DCSK demodulator top: frame FSM, bit counter and message shift
// register around the dcsk_corr correlator.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_sf                      chips per half-bit, latched on i_start (clamped)
//   i_start                   frame start / abort-and-restart
//   i_chip_valid, i_chip      received chip stream (1 = +1, 0 = -1)
//   o_busy                    frame in progress
//   o_bit, o_tie, o_bit_valid last decision, its low-confidence flag, pulse
//   o_msg, o_msg_valid        last complete word (first bit at MSB), pulse
module dcsk_demod
  import dcsk_pkg::*;
#(
  parameter int unsigned MAX_SF = DCSK_MAX_SF,
  parameter int unsigned MSG_W  = DCSK_MSG_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [$clog2(MAX_SF):0] i_sf,
  input  logic                    i_start,
  input  logic                    i_chip_valid,
  input  logic                    i_chip,
  output logic                    o_busy,
  output logic                    o_bit,
  output logic                    o_bit_valid,
  output logic                    o_tie,
  output logic [MSG_W-1:0]        o_msg,
  output logic                    o_msg_valid
);

  localparam int unsigned SF_W = $clog2(MAX_SF) + 1;
  localparam int unsigned BC_W = $clog2(MSG_W + 1);

  dcsk_demod_state_t state_q, state_d, st_cur;
  logic [SF_W-1:0]   sf_q, sf_cur;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d, bit_cnt_cur;
  logic [MSG_W-1:0]  shift_q, shift_d, shift_cur, shift_nxt;
  logic              half, chip_acc, decide, last_bit;
  logic              corr_done, corr_bit, corr_tie;

  // i_start overrides the registered frame context for this cycle, which
  // both aborts a running frame and lets a same-cycle chip become ref[0].
  always_comb begin
    sf_cur      = i_start ? SF_W'(clamp_sf(32'(i_sf), MAX_SF)) : sf_q;
    st_cur      = i_start ? REF : state_q;
    bit_cnt_cur = i_start ? '0 : bit_cnt_q;
    shift_cur   = i_start ? '0 : shift_q;
    half        = (st_cur == DATA);
    chip_acc    = i_chip_valid && (st_cur != IDLE);
    decide      = chip_acc && corr_done && half;
    last_bit    = (bit_cnt_cur == BC_W'(MSG_W - 1));
    shift_nxt   = (shift_cur << 1) | MSG_W'(corr_bit);

    state_d = st_cur;
    if (chip_acc && corr_done) begin
      unique case (st_cur)
        REF:     state_d = DATA;
        DATA:    state_d = last_bit ? IDLE : REF;
        default: state_d = IDLE;
      endcase
    end

    bit_cnt_d = bit_cnt_cur;
    shift_d   = shift_cur;
    if (decide) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_cur + BC_W'(1);
      shift_d   = last_bit ? '0 : shift_nxt;
    end
  end

  dcsk_corr #(
    .MAX_SF(MAX_SF)
  ) u_corr (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (i_start),
    .sf      (sf_cur),
    .half    (half),
    .valid   (chip_acc),
    .chip    (i_chip),
    .done    (corr_done),
    .dec_bit (corr_bit),
    .tie     (corr_tie)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      sf_q        <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      o_bit       <= 1'b0;
      o_tie       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_msg       <= '0;
      o_msg_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      sf_q        <= sf_cur;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      o_bit_valid <= decide;
      o_msg_valid <= decide && last_bit;
      if (decide) begin
        o_bit <= corr_bit;
        o_tie <= corr_tie;
      end
      if (decide && last_bit) begin
        o_msg <= shift_nxt;
      end
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_dcsk_demod.sv
module tb_dcsk_demod;

  localparam int unsigned MAX_SF = 32;
  localparam int unsigned MSG_W  = 8;

  logic                    i_clk = 1'b0;
  logic                    i_rst;
  logic [$clog2(MAX_SF):0] i_sf;
  logic                    i_start;
  logic                    i_chip_valid;
  logic                    i_chip;
  logic                    o_busy;
  logic                    o_bit;
  logic                    o_bit_valid;
  logic                    o_tie;
  logic [MSG_W-1:0]        o_msg;
  logic                    o_msg_valid;

  int n_total = 0;
  int n_pass  = 0;

  logic [1:0]       bit_q[$];  // {tie, bit} per decision pulse
  logic [MSG_W-1:0] msg_q[$];

  always #5 i_clk = ~i_clk;

  dcsk_demod #(
    .MAX_SF(MAX_SF),
    .MSG_W (MSG_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sf        (i_sf),
    .i_start     (i_start),
    .i_chip_valid(i_chip_valid),
    .i_chip      (i_chip),
    .o_busy      (o_busy),
    .o_bit       (o_bit),
    .o_bit_valid (o_bit_valid),
    .o_tie       (o_tie),
    .o_msg       (o_msg),
    .o_msg_valid (o_msg_valid)
  );

  // Outputs move on posedge; collect pulses half a cycle later.
  always @(negedge i_clk) begin
    if (o_bit_valid) bit_q.push_back({o_tie, o_bit});
    if (o_msg_valid) msg_q.push_back(o_msg);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference chips for bit k: a rotating slice of a fixed pattern.
  function automatic logic ref_chip(input int k, input int i);
    logic [31:0] p;
    p = 32'hB2C3_9E5D;
    return p[(i + 5 * k) % 32];
  endfunction

  task automatic idle(input int n);
    i_start      = 1'b0;
    i_chip_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // One accepted chip, optionally preceded by gap invalid cycles.
  task automatic send_chip(input logic st, input logic c, input int gap);
    for (int g = 0; g < gap; g++) begin
      i_start      = 1'b0;
      i_chip_valid = 1'b0;
      i_chip       = 1'($urandom);
      @(posedge i_clk);
      #1;
    end
    i_start      = st;
    i_chip_valid = 1'b1;
    i_chip       = c;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  // n ref chips then n data chips, element i of each vector sent i-th.
  task automatic send_raw(input logic [31:0] refv, input logic [31:0] datv, input int n,
                          input logic st, input int gap, input int sf_mid);
    for (int i = 0; i < n; i++) begin
      send_chip(st && i == 0, refv[i], gap);
      if (st && i == 0) i_sf = 6'(sf_mid);
    end
    for (int i = 0; i < n; i++) send_chip(1'b0, datv[i], gap);
  endtask

  task automatic send_bit(input logic b, input int sf, input int k, input logic st,
                          input int gap, input int sf_mid);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = ref_chip(k, i);
    send_raw(r, b ? r : ~r, sf, st, gap, sf_mid);
  endtask

  task automatic send_frame(input logic [7:0] msg, input int sf_in, input int sf_tx,
                            input int gap, input int sf_mid);
    i_sf = 6'(sf_in);
    for (int k = 0; k < 8; k++) send_bit(msg[7-k], sf_tx, k, k == 0, gap, sf_mid);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] msg);
    check({tag, "_nbits"}, 32'(bit_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < bit_q.size(); k++)
      check($sformatf("%s_bit%0d", tag, k), 32'(bit_q[k]), {31'd0, msg[7-k]});
    check({tag, "_nmsg"}, 32'(msg_q.size()), 32'd1);
    if (msg_q.size() > 0) check({tag, "_msg"}, 32'(msg_q[0]), 32'(msg));
  endtask

  initial begin
    logic [7:0] rv;
    i_rst = 1'b1; i_sf = '0; i_start = 1'b0; i_chip_valid = 1'b0; i_chip = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_bitv", 32'(o_bit_valid), 0);
    check("rst_msg", 32'(o_msg), 0);
    check("rst_tie", 32'(o_tie), 0);

    // 1: ideal stream, SF=4, 0xA5
    bit_q.delete(); msg_q.delete();
    send_frame(8'hA5, 4, 4, 0, 4);
    check("s1_bitv_lat", 32'(o_bit_valid), 1);
    check("s1_msgv_lat", 32'(o_msg_valid), 1);
    idle(3);
    check("s1_busy_end", 32'(o_busy), 0);
    check_frame("s1", 8'hA5);

    // 2: SF=8 correlation boundaries, ref sequence 1,0,1,1,0,0,1,0
    rv = 8'b0100_1101;
    bit_q.delete();
    i_sf = 6'd8;
    send_raw({24'd0, rv}, {24'd0, ~rv}, 8, 1'b1, 0, 8);
    check("s2_inv_bit", 32'(o_bit), 0);
    check("s2_inv_tie", 32'(o_tie), 0);
    send_raw({24'd0, rv}, {24'd0, rv ^ 8'h03}, 8, 1'b0, 0, 8);
    check("s2_m6_bit", 32'(o_bit), 1);
    send_raw({24'd0, rv}, {24'd0, rv ^ 8'h07}, 8, 1'b0, 0, 8);
    check("s2_m5_bit", 32'(o_bit), 1);
    check("s2_m5_tie", 32'(o_tie), 0);
    send_raw({24'd0, rv}, {24'd0, rv ^ 8'h1F}, 8, 1'b0, 0, 8);
    check("s2_m3_bit", 32'(o_bit), 0);
    send_raw({24'd0, rv}, {24'd0, rv ^ 8'h0F}, 8, 1'b0, 0, 8);
    check("s2_tie_bit", 32'(o_bit), 0);
    check("s2_tie_tie", 32'(o_tie), 1);
    idle(4);
    check("s2_tie_hold", 32'(o_tie), 1);
    check("s2_busy", 32'(o_busy), 1);
    check("s2_npulse", 32'(bit_q.size()), 5);

    // 3: gapped stream; also aborts the partial frame above
    bit_q.delete(); msg_q.delete();
    send_frame(8'hA5, 4, 4, 1, 4);
    check("s3_bitv_lat", 32'(o_bit_valid), 1);
    idle(3);
    check_frame("s3", 8'hA5);

    // 4: abort mid-DATA of bit 3, then a fresh frame
    bit_q.delete(); msg_q.delete();
    i_sf = 6'd4;
    for (int k = 0; k < 3; k++) send_bit(1'(8'h3C >> (7 - k)), 4, k, k == 0, 0, 4);
    for (int i = 0; i < 4; i++) send_chip(1'b0, ref_chip(3, i), 0);
    for (int i = 0; i < 2; i++) send_chip(1'b0, ref_chip(3, i), 0);
    check("s4_pre_nbits", 32'(bit_q.size()), 3);
    bit_q.delete();
    send_frame(8'h5A, 4, 4, 0, 4);
    idle(3);
    check_frame("s4", 8'h5A);

    // 5: clamp of i_sf=0 and i_sf=40 to 32, mid-frame i_sf changes ignored
    bit_q.delete(); msg_q.delete();
    send_frame(8'h96, 0, 32, 0, 4);
    idle(3);
    check_frame("s5a", 8'h96);
    bit_q.delete(); msg_q.delete();
    send_frame(8'h69, 40, 32, 0, 2);
    idle(3);
    check_frame("s5b", 8'h69);
    check("s5_bit_hold", 32'(o_bit), 1);

    // 6: reset mid-REF with chips still streaming
    bit_q.delete(); msg_q.delete();
    i_sf = 6'd4;
    send_chip(1'b1, 1'b1, 0);
    send_chip(1'b0, 1'b0, 0);
    i_rst = 1'b1;
    send_chip(1'b0, 1'b1, 0);
    i_rst = 1'b0;
    check("s6_busy", 32'(o_busy), 0);
    check("s6_bit", 32'(o_bit), 0);
    check("s6_msg", 32'(o_msg), 0);
    check("s6_bitv", 32'(o_bit_valid), 0);
    for (int i = 0; i < 20; i++) send_chip(1'b0, 1'($urandom), 0);
    idle(2);
    check("s6_ignored_busy", 32'(o_busy), 0);
    check("s6_ignored_pulses", 32'(bit_q.size()), 0);

    // Recovery after reset
    bit_q.delete(); msg_q.delete();
    send_frame(8'hC3, 4, 4, 0, 4);
    idle(3);
    check_frame("s6r", 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
